// File: rtl/calc_pkg.sv
// Seven-segment glyph table and symbol codes shared by the display encoder and decoder.
// Pure constants; no timing or flow control.
package calc_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NUM_GLYPHS = 19;
  localparam int SYM_W      = 5;

  typedef enum logic [4:0] {
    SYM_0 = 5'd0,  SYM_1 = 5'd1,  SYM_2 = 5'd2,  SYM_3 = 5'd3,
    SYM_4 = 5'd4,  SYM_5 = 5'd5,  SYM_6 = 5'd6,  SYM_7 = 5'd7,
    SYM_8 = 5'd8,  SYM_9 = 5'd9,  SYM_A = 5'd10, SYM_B = 5'd11,
    SYM_C = 5'd12, SYM_D = 5'd13, SYM_E = 5'd14, SYM_F = 5'd15,
    SYM_R = 5'd16, SYM_O = 5'd17, SYM_BLANK = 5'd18,
    SYM_INVALID = 5'd31
  } sym_t;

  // Lit-segment patterns (g..a), indexed by symbol code.
  localparam logic [6:0] GLYPH_PAT [NUM_GLYPHS] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
    7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71, 7'h50, 7'h5C, 7'h00
  };

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational lit-segment pattern to symbol code lookup; unknown patterns give SYM_INVALID.
// Zero latency, no flow control.
module seg_glyph_decode
  import calc_pkg::*;
(
  input  logic [6:0] lit,
  output logic [4:0] code,
  output logic       valid
);

  always_comb begin
    code  = SYM_INVALID;
    valid = 1'b0;
    for (int i = 0; i < NUM_GLYPHS; i++) begin
      if (lit == GLYPH_PAT[i]) begin
        code  = 5'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_decoder.sv
// Recovers digit symbols from a multiplexed active-low 7-segment scan and publishes whole frames.
// Publishes one cycle after the eighth digit is seen; no backpressure, frames are pulses.
module display_decoder
  import calc_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  segments,
  input  logic [7:0]  segments_control,
  output logic [39:0] digits,
  output logic [7:0]  dots,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        err_select,
  output logic        err_glyph,
  output logic        stalled
);

  localparam int DW = NUM_DIGITS * SYM_W;
  localparam logic [DW-1:0] BLANK_FRAME = {NUM_DIGITS{5'd18}};
  localparam logic [3:0]    SETTLE_W    = 4'(SETTLE);
  localparam logic [15:0]   TIMEOUT_W   = 16'(TIMEOUT);

  logic [7:0]    seg_q, seg_d, sel_q, sel_d, prev_sel_q, prev_sel_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] shadow_q, shadow_d, digits_q, digits_d;
  logic [7:0]    shadow_dot_q, shadow_dot_d, dots_q, dots_d, seen_q, seen_d;
  logic          fv_q, fv_d, fc_q, fc_d, err_sel_q, err_sel_d, err_glyph_q, err_glyph_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic [7:0] sel_n;
  logic [6:0] lit;
  logic [4:0] code;
  logic       code_valid, changed, sel_onehot, sel_blank, settled, capture, publish;

  assign sel_n      = ~sel_q;
  assign lit        = ~seg_q[6:0];
  assign changed    = (sel_q != prev_sel_q);
  assign sel_onehot = (sel_n != 8'd0) && ((sel_n & (sel_n - 8'd1)) == 8'd0);
  assign sel_blank  = (sel_q == 8'hFF);
  assign publish    = (seen_q == 8'hFF);

  seg_glyph_decode u_glyph (
    .lit   (lit),
    .code  (code),
    .valid (code_valid)
  );

  always_comb begin
    seg_d        = segments;
    sel_d        = segments_control;
    prev_sel_d   = sel_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    shadow_dot_d = shadow_dot_q;
    seen_d       = seen_q;
    digits_d     = digits_q;
    dots_d       = dots_q;
    err_sel_d    = err_sel_q;
    err_glyph_d  = err_glyph_q;
    stall_cnt_d  = stall_cnt_q;

    if (changed) begin
      cnt_d = 4'd1;
    end else if (cnt_q < SETTLE_W) begin
      cnt_d = cnt_q + 4'd1;
    end
    // Fire only on arrival at SETTLE, so a long-held select captures once.
    settled = (cnt_d == SETTLE_W) && (changed || (cnt_q != SETTLE_W));
    capture = settled && sel_onehot;

    if (!sel_onehot && !sel_blank) begin
      err_sel_d = 1'b1;
    end

    fv_d = publish;
    fc_d = publish && ({shadow_q, shadow_dot_q} != {digits_q, dots_q});
    if (publish) begin
      digits_d = shadow_q;
      dots_d   = shadow_dot_q;
      seen_d   = 8'd0;
    end

    // Applied after publish so a coincident capture seeds the next frame.
    if (capture) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (sel_n[d]) begin
          shadow_d[d*SYM_W +: SYM_W] = code;
          shadow_dot_d[d]            = ~seg_q[7];
          seen_d[d]                  = 1'b1;
        end
      end
      if (!code_valid) begin
        err_glyph_d = 1'b1;
      end
    end

    if (fv_q) begin
      stall_cnt_d = 16'd0;
    end else if (stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_q        <= 8'hFF;
      sel_q        <= 8'hFF;
      prev_sel_q   <= 8'hFF;
      cnt_q        <= 4'd0;
      shadow_q     <= BLANK_FRAME;
      shadow_dot_q <= 8'd0;
      seen_q       <= 8'd0;
      digits_q     <= BLANK_FRAME;
      dots_q       <= 8'd0;
      fv_q         <= 1'b0;
      fc_q         <= 1'b0;
      err_sel_q    <= 1'b0;
      err_glyph_q  <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      prev_sel_q   <= prev_sel_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      shadow_dot_q <= shadow_dot_d;
      seen_q       <= seen_d;
      digits_q     <= digits_d;
      dots_q       <= dots_d;
      fv_q         <= fv_d;
      fc_q         <= fc_d;
      err_sel_q    <= err_sel_d;
      err_glyph_q  <= err_glyph_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign digits        = digits_q;
  assign dots          = dots_q;
  assign frame_valid   = fv_q;
  assign frame_changed = fc_q;
  assign err_select    = err_sel_q;
  assign err_glyph     = err_glyph_q;
  assign stalled       = (stall_cnt_q >= TIMEOUT_W);

endmodule

// File: tb/tb_display_decoder.sv
// Frame-level bench for display_decoder: scan vectors, scoreboard of published frames, corner sequences.
module tb_display_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  segments = 8'hFF;
  logic [7:0]  segments_control = 8'hFF;
  logic [39:0] digits;
  logic [7:0]  dots;
  logic        frame_valid, frame_changed, err_select, err_glyph, stalled;

  always #5 clock = ~clock;

  display_decoder #(.SETTLE(2), .TIMEOUT(100)) dut (
    .clock            (clock),
    .reset            (reset),
    .segments         (segments),
    .segments_control (segments_control),
    .digits           (digits),
    .dots             (dots),
    .frame_valid      (frame_valid),
    .frame_changed    (frame_changed),
    .err_select       (err_select),
    .err_glyph        (err_glyph),
    .stalled          (stalled)
  );

  typedef struct {
    logic [7:0][4:0] codes;
    logic [7:0]      dts;
    logic            chg;
  } vec_t;

  typedef struct {
    logic [39:0] dig;
    logic [7:0]  dot;
    logic        chg;
  } exp_t;

  vec_t        vecs [5];
  exp_t        sb [$];
  int          total = 0;
  int          bad = 0;
  logic [39:0] blank_frame = {8{5'd18}};
  logic [39:0] mon_dig = {8{5'd18}};
  logic [7:0]  mon_dots = 8'd0;
  logic        mon_fv = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] pat_of(input logic [4:0] c);
    case (c)
      5'd0:  return 7'h3F;  5'd1:  return 7'h06;  5'd2:  return 7'h5B;
      5'd3:  return 7'h4F;  5'd4:  return 7'h66;  5'd5:  return 7'h6D;
      5'd6:  return 7'h7D;  5'd7:  return 7'h07;  5'd8:  return 7'h7F;
      5'd9:  return 7'h6F;  5'd10: return 7'h77;  5'd11: return 7'h7C;
      5'd12: return 7'h58;  5'd13: return 7'h5E;  5'd14: return 7'h79;
      5'd15: return 7'h71;  5'd16: return 7'h50;  5'd17: return 7'h5C;
      5'd18: return 7'h00;
      default: return 7'h01;
    endcase
  endfunction

  task automatic drive_digit(input int d, input logic [4:0] c, input logic dot, input int hold);
    segments_control = ~(8'd1 << d);
    segments         = ~{dot, pat_of(c)};
    repeat (hold) @(negedge clock);
  endtask

  task automatic scan(input logic [39:0] codes, input logic [7:0] dts, input int first, input int last);
    for (int d = first; d >= last; d--) begin
      drive_digit(d, codes[d*5 +: 5], dts[d], 4);
    end
    segments_control = 8'hFF;
    segments         = 8'hFF;
  endtask

  task automatic push_exp(input logic [39:0] dig, input logic [7:0] dot, input logic chg);
    exp_t e;
    e.dig = dig;
    e.dot = dot;
    e.chg = chg;
    sb.push_back(e);
  endtask

  task automatic wait_frame();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (frame_valid) found = 1'b1;
      else @(negedge clock);
    end
    check("frame_arrived", found, 1);
  endtask

  // Scoreboard consumer plus hold / single-pulse properties.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (frame_valid) begin
          check("frame_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("frame_digits", digits, e.dig);
            check("frame_dots", dots, e.dot);
            check("frame_changed", frame_changed, e.chg);
          end
          check("fv_single_cycle", mon_fv, 0);
        end else begin
          check("digits_hold", digits, mon_dig);
          check("dots_hold", dots, mon_dots);
          check("fc_without_fv", frame_changed, 0);
        end
      end
      mon_dig  = digits;
      mon_dots = dots;
      mon_fv   = frame_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    logic [39:0] g, ge;

    vecs[0] = '{'{5'd18, 5'd18, 5'd18, 5'd18, 5'd18, 5'd1, 5'd2, 5'd3}, 8'h00, 1'b1};
    vecs[1] = '{'{5'd18, 5'd18, 5'd18, 5'd18, 5'd18, 5'd1, 5'd2, 5'd3}, 8'h00, 1'b0};
    vecs[2] = '{'{5'd18, 5'd0, 5'd18, 5'd18, 5'd18, 5'd18, 5'd7, 5'd11}, 8'h00, 1'b1};
    vecs[3] = '{'{5'd14, 5'd16, 5'd16, 5'd17, 5'd0, 5'd8, 5'd9, 5'd10}, 8'h81, 1'b1};
    vecs[4] = '{'{5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd31, 5'd15, 5'd0}, 8'h10, 1'b1};

    repeat (2) @(negedge clock);
    check("rst_digits", digits, blank_frame);
    check("rst_dots", dots, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_fc", frame_changed, 0);
    check("rst_err_select", err_select, 0);
    check("rst_err_glyph", err_glyph, 0);
    check("rst_stalled", stalled, 0);
    reset = 1'b0;

    repeat (99) @(negedge clock);
    check("stall_before_timeout", stalled, 0);
    @(negedge clock);
    check("stall_at_timeout", stalled, 1);

    for (int v = 0; v < 5; v++) begin
      if (v == 4) check("err_glyph_clear", err_glyph, 0);
      push_exp(vecs[v].codes, vecs[v].dts, vecs[v].chg);
      scan(vecs[v].codes, vecs[v].dts, 7, 0);
      wait_frame();
      if (v == 0) begin
        check("stall_at_frame", stalled, 1);
        @(negedge clock);
        check("stall_cleared", stalled, 0);
      end
      if (v == 4) check("err_glyph_set", err_glyph, 1);
      repeat (3) @(negedge clock);
    end

    // Illegal two-hot select mid-scan.
    check("err_select_clear", err_select, 0);
    push_exp(vecs[3].codes, vecs[3].dts, 1'b1);
    scan(vecs[3].codes, vecs[3].dts, 7, 4);
    segments_control = 8'b1111_1100;
    segments         = ~{1'b1, pat_of(5'd8)};
    repeat (3) @(negedge clock);
    check("err_select_set", err_select, 1);
    scan(vecs[3].codes, vecs[3].dts, 3, 0);
    wait_frame();
    repeat (3) @(negedge clock);
    check("err_select_sticky", err_select, 1);

    // Re-capture of digit 6 (latest wins) and a one-cycle glitch onto digit 5.
    g  = vecs[2].codes;
    ge = g;
    ge[30 +: 5] = 5'd3;
    push_exp(ge, 8'h00, 1'b1);
    scan(g, 8'h00, 7, 4);
    drive_digit(6, 5'd3, 1'b0, 4);
    drive_digit(5, 5'd9, 1'b1, 1);
    scan(g, 8'h00, 3, 0);
    wait_frame();
    repeat (3) @(negedge clock);

    // Reset after five digits; the partial frame must not leak into the next one.
    scan({8{5'd8}}, 8'hFF, 7, 3);
    #2 reset = 1'b1;
    #1;
    check("midrst_digits", digits, blank_frame);
    check("midrst_dots", dots, 0);
    check("midrst_fv", frame_valid, 0);
    check("midrst_err_select", err_select, 0);
    check("midrst_err_glyph", err_glyph, 0);
    check("midrst_stalled", stalled, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    scan(vecs[3].codes, vecs[3].dts, 2, 0);
    repeat (3) @(negedge clock);
    push_exp(vecs[3].codes, vecs[3].dts, 1'b1);
    scan(vecs[3].codes, vecs[3].dts, 7, 3);
    wait_frame();
    check("post_rst_err_glyph", err_glyph, 0);

    repeat (5) @(negedge clock);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_decoder.md
DISPLAY_DECODER -- requirements
Module: display_decoder

Interface
REQ-001 Parameter SETTLE, default 2: consecutive cycles a digit select must be stable before its segments are captured (range 1..15).
REQ-002 Parameter TIMEOUT, default 65535: cycles without a completed frame before `stalled` asserts (16-bit).
REQ-003 clock  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 segments  input  8  active-low segment lines; bit7 = dot, bits6:0 = g..a.
REQ-006 segments_control  input  8  active-low one-hot digit select; bit0 = rightmost digit 0, bit7 = leftmost digit 7.
REQ-007 digits  output  40  8 x 5-bit symbol codes; digits[4:0] = digit 0.
REQ-008 dots  output  8  decoded dot per digit, 1 = lit.
REQ-009 frame_valid  output  1  one-cycle pulse when a complete frame is published.
REQ-010 frame_changed  output  1  one-cycle pulse, coincident with frame_valid, when published digits/dots differ from the previous frame.
REQ-011 err_select  output  1  sticky; a select value other than one-hot or all-ones was observed.
REQ-012 err_glyph  output  1  sticky; an unrecognised segment pattern was captured.
REQ-013 stalled  output  1  level; no frame completed within TIMEOUT cycles.

Function
REQ-014 Inputs are registered once on entry; all decisions use the registered copies.
REQ-015 Lit pattern = ~segments[6:0]; glyph codes: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9, 0x77->10(A), 0x7C->11(b), 0x58->12(c), 0x5E->13(d), 0x79->14(E), 0x71->15(F), 0x50->16(r), 0x5C->17(o), 0x00->18(blank); any other pattern -> 31 and sets err_glyph.
REQ-016 Stability counter resets to 1 whenever the registered select differs from its previous value and saturates at SETTLE.
REQ-017 On the cycle the counter reaches SETTLE with a one-hot select for digit d: shadow[d] <= glyph code, shadow dot[d] <= ~segments[7], seen[d] <= 1; exactly one capture per stable window.
REQ-018 A digit re-captured before frame completion overwrites its shadow entry (latest wins).
REQ-019 All-ones select (blanking) is ignored: no capture, no error.
REQ-020 Non-one-hot, non-all-ones select: set err_select, no capture, seen unchanged.
REQ-021 When seen becomes 8'hFF, the next cycle: digits/dots <= shadow atomically, frame_valid = 1, frame_changed = (shadow != previously published), seen <= 0.
REQ-022 A capture coincident with publication belongs to the next frame.
REQ-023 digits/dots change only at publication; they hold between frames.
REQ-024 Stall counter: cleared on frame_valid, else increments, saturating; stalled = (counter >= TIMEOUT); deasserts the cycle after the next frame_valid.
REQ-025 frame_valid and frame_changed are never asserted for more than one consecutive cycle.

Reset
REQ-026 While reset is high: digits = all code 18 (blank), dots = 0, seen = 0, shadow = blank, frame_valid = frame_changed = 0, err_select = err_glyph = 0, stalled = 0, counters = 0, registered select = 8'hFF.
REQ-027 Reset mid-frame discards the partial frame; sticky errors clear only by reset.

Structure
REQ-028 Shared package calc_pkg holds the 19 glyph patterns, symbol codes (0..18, INVALID = 31) and NUM_DIGITS = 8; the existing display encoder uses the same constants.
REQ-029 One sub-module, seg_glyph_decode: combinational 7-bit pattern -> 5-bit code plus valid flag.

Verification
REQ-030 Scan digits 0..7 with patterns for "     123" (select held 4 cycles each) -> frame_valid once, digits = {18,18,18,18,18,1,2,3}, frame_changed = 1.
REQ-031 Repeat the identical frame -> frame_valid = 1, frame_changed = 0; then "      7b" -> digits[9:0] = {7,11}, frame_changed = 1.
REQ-032 Select 8'b11111100 for 3 cycles mid-scan -> err_select = 1 sticky, no capture, frame completes normally afterwards.
REQ-033 Lit pattern 0x01 on digit 2 -> published code 31 at digit 2, err_glyph = 1; select glitch of 1 cycle with SETTLE = 2 -> no capture.
REQ-034 Assert reset after 5 of 8 digits captured -> outputs at reset values; next full scan publishes a clean frame.
REQ-035 TIMEOUT = 100, no scanning -> stalled = 1 from cycle 100; complete a frame -> stalled = 0 the following cycle.
